// File: rtl/fir_stream_pkg.sv
// Shared constants for the FIR streaming path and a constant-foldable clog2
// used to size occupancy counters.
package fir_stream_pkg;

    localparam int FIR_DATA_W = 6;
    localparam int FIR_OUT_W  = 8;
    localparam int SRC_DEPTH  = 8;
    localparam int SRC_DIV_W  = 8;

    // Number of bits needed to index 'value' entries (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous register-based FIFO with an exact 0..DEPTH occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sample_fifo
    import fir_stream_pkg::*;
#(
    parameter int WIDTH = FIR_DATA_W,
    parameter int DEPTH = SRC_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [clog2(DEPTH):0] level_o
);

    localparam int             AW         = clog2(DEPTH);
    localparam logic [AW:0]    FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full_o  = (level_q == FULL_LEVEL);
        empty_o = (level_q == '0);
        level_o = level_q;
        head_o  = mem_q[rd_ptr_q];

        // A push into a full FIFO is legal only when the head leaves in the same cycle.
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);

        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage has no reset; pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/axis_sample_source.sv
// Paced AXI-stream sample source: FIFO, rate divider, one-slot credit and output register.
// Optional SAMPLE_SRC_TLAST_EN carries a tlast bit alongside every sample.
module axis_sample_source
    import fir_stream_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int DEPTH  = SRC_DEPTH,
    parameter int DIV_W  = SRC_DIV_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_en,
`ifdef SAMPLE_SRC_TLAST_EN
    input  logic                  wr_last,
`endif
    input  logic [DIV_W-1:0]      rate_div,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic                  m_axis_tvalid,
`ifdef SAMPLE_SRC_TLAST_EN
    output logic                  m_axis_tlast,
`endif
    input  logic                  m_axis_tready,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [clog2(DEPTH):0] fifo_level,
    output logic                  overflow
);

`ifdef SAMPLE_SRC_TLAST_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic               credit_q, credit_d;
    logic [ENTRY_W-1:0] out_q, out_d;
    logic               tvalid_q, tvalid_d;
    logic               overflow_q, overflow_d;

    logic               tick;
    logic               load;
    logic               push_ok;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

`ifdef SAMPLE_SRC_TLAST_EN
    assign push_entry = {wr_last, wr_data};
`else
    assign push_entry = wr_data;
`endif

    sample_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_ok),
        .push_data_i (push_entry),
        .pop_i       (load),
        .head_o      (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    always_comb begin
        // >= rather than == so lowering rate_div below the count ticks immediately.
        tick    = (cnt_q >= rate_div);
        load    = (tick | credit_q) & ~fifo_empty & (~tvalid_q | m_axis_tready);
        push_ok = wr_en & (~fifo_full | load);

        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        credit_d   = load ? 1'b0 : (tick | credit_q);
        overflow_d = overflow_q | (wr_en & fifo_full & ~load);

        out_d    = out_q;
        tvalid_d = tvalid_q;
        if (load) begin
            out_d    = head_entry;
            tvalid_d = 1'b1;
        end else if (tvalid_q & m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            credit_q   <= 1'b0;
            out_q      <= '0;
            tvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            credit_q   <= credit_d;
            out_q      <= out_d;
            tvalid_q   <= tvalid_d;
            overflow_q <= overflow_d;
        end
    end

    assign m_axis_tdata  = out_q[DATA_W-1:0];
    assign m_axis_tvalid = tvalid_q;
    assign overflow      = overflow_q;
`ifdef SAMPLE_SRC_TLAST_EN
    assign m_axis_tlast  = out_q[DATA_W];
`endif

endmodule

// File: tb/tb_axis_sample_source.sv
// Self-checking bench for axis_sample_source: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model of the source.
module tb_axis_sample_source;
    import fir_stream_pkg::*;

    localparam int DW    = FIR_DATA_W;
    localparam int DEPTH = SRC_DEPTH;
    localparam int LW    = clog2(DEPTH) + 1;
`ifdef SAMPLE_SRC_TLAST_EN
    localparam int EW    = DW + 1;
`else
    localparam int EW    = DW;
`endif
    localparam int OBS_W = 1 + EW + LW + 3;
    // {tvalid, entry, level, full, empty, overflow} right after reset: only empty is set.
    localparam logic [OBS_W-1:0] RST_OBS = OBS_W'(2);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic [7:0]    rate_div = '0;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          overflow;
`ifdef SAMPLE_SRC_TLAST_EN
    logic          wr_last = 1'b0;
    logic          m_axis_tlast;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axis_sample_source dut (
        .clk           (clk),
        .reset         (reset),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
`ifdef SAMPLE_SRC_TLAST_EN
        .wr_last       (wr_last),
        .m_axis_tlast  (m_axis_tlast),
`endif
        .rate_div      (rate_div),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_level    (fifo_level),
        .overflow      (overflow)
    );

    // Reference model: sample queue, pacing count, one-slot credit, output slot.
    logic [EW-1:0] mdl_q[$];
    logic [EW-1:0] mdl_out = '0;
    int            mdl_cnt = 0;
    bit            mdl_credit = 1'b0;
    bit            mdl_valid = 1'b0;
    bit            mdl_ovf = 1'b0;
    logic [EW-1:0] wr_entry;

`ifdef SAMPLE_SRC_TLAST_EN
    assign wr_entry = {wr_last, wr_data};
`else
    assign wr_entry = wr_data;
`endif

    always @(posedge clk or posedge reset) begin
        bit tick;
        bit load;
        bit accept;
        if (reset) begin
            mdl_q.delete();
            mdl_out    = '0;
            mdl_cnt    = 0;
            mdl_credit = 1'b0;
            mdl_valid  = 1'b0;
            mdl_ovf    = 1'b0;
        end else begin
            tick   = (mdl_cnt >= int'(rate_div));
            load   = (tick || mdl_credit) && (mdl_q.size() > 0) && (!mdl_valid || m_axis_tready);
            accept = wr_en && ((mdl_q.size() < DEPTH) || load);
            if (mdl_valid && m_axis_tready) mdl_valid = 1'b0;
            if (load) begin
                mdl_out   = mdl_q.pop_front();
                mdl_valid = 1'b1;
            end
            if (accept) mdl_q.push_back(wr_entry);
            else if (wr_en) mdl_ovf = 1'b1;
            mdl_credit = load ? 1'b0 : (tick || mdl_credit);
            mdl_cnt    = tick ? 0 : mdl_cnt + 1;
        end
    end

    function automatic logic [OBS_W-1:0] dut_obs();
        logic [EW-1:0] e;
`ifdef SAMPLE_SRC_TLAST_EN
        e = {m_axis_tlast, m_axis_tdata};
`else
        e = m_axis_tdata;
`endif
        return {m_axis_tvalid, e, fifo_level, fifo_full, fifo_empty, overflow};
    endfunction

    function automatic logic [OBS_W-1:0] model_obs();
        int n;
        n = mdl_q.size();
        return {mdl_valid, mdl_out, LW'(n), n == DEPTH, n == 0, mdl_ovf};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b0;
        m_axis_tready = 1'b0;
        rate_div = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b0;
        #1;
        if (dut_obs() !== RST_OBS) begin
            errors++;
            $display("FAIL reset_held: got %h want %h", dut_obs(), RST_OBS);
        end
        checks++;
        @(negedge clk);
        reset = 1'b0;
        if (dut_obs() !== model_obs()) begin
            errors++;
            $display("FAIL reset_model: got %h want %h", dut_obs(), model_obs());
        end
        checks++;
    endtask

    task automatic test_basic();
        logic [DW-1:0] smp[3];
        bit            exp_v[5];
        logic [DW-1:0] exp_d[5];
        smp   = '{6'd3, 6'd5, 6'd7};
        exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_d = '{6'd0, 6'd3, 6'd5, 6'd7, 6'd0};
        do_reset();
        rate_div = 8'd0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en   = (i < 3);
            wr_data = (i < 3) ? smp[i] : '0;
            @(negedge clk);
            if (m_axis_tvalid !== exp_v[i] || (exp_v[i] && m_axis_tdata !== exp_d[i])) begin
                errors++;
                $display("FAIL basic_seq edge %0d: tvalid=%b tdata=%0d want tvalid=%b tdata=%0d",
                         i + 1, m_axis_tvalid, m_axis_tdata, exp_v[i], exp_d[i]);
            end
            checks++;
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL basic_model edge %0d: got %h want %h", i + 1, dut_obs(), model_obs());
            end
            checks++;
        end
        if (fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_empty: got %b want 1", fifo_empty);
        end
        checks++;
    endtask

    task automatic test_pacing();
        logic [DW-1:0] smp[8];
        int            k;
        foreach (smp[j]) smp[j] = DW'($urandom);
        do_reset();
        rate_div = 8'd3;
        m_axis_tready = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (k >= 8 || (i + 1) != 5 + 4 * k || m_axis_tdata !== smp[k]) begin
                    errors++;
                    $display("FAIL pacing_xfer #%0d: edge %0d data %0d want edge %0d data %0d",
                             k, i + 1, m_axis_tdata, 5 + 4 * k, (k < 8) ? smp[k] : '0);
                end
                checks++;
                k++;
            end
            wr_en   = (i < 8);
            wr_data = (i < 8) ? smp[i] : '0;
            @(negedge clk);
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL pacing_model edge %0d: got %h want %h", i + 1, dut_obs(), model_obs());
            end
            checks++;
        end
        if (k != 8) begin
            errors++;
            $display("FAIL pacing_count: got %0d transfers want 8", k);
        end
        checks++;
    endtask

    task automatic test_stall();
        int xfers;
        do_reset();
        rate_div = 8'd0;
        m_axis_tready = 1'b0;
        wr_en   = 1'b1;
        wr_data = 6'h2A;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 6'h2A) begin
                errors++;
                $display("FAIL stall_hold cyc %0d: tvalid=%b tdata=%h want 1/2a", i, m_axis_tvalid, m_axis_tdata);
            end
            checks++;
            @(negedge clk);
        end
        m_axis_tready = 1'b1;
        xfers = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_axis_tvalid) xfers++;
            @(negedge clk);
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL stall_model cyc %0d: got %h want %h", i, dut_obs(), model_obs());
            end
            checks++;
        end
        if (xfers != 1 || m_axis_tvalid !== 1'b0 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: transfers=%0d tvalid=%b empty=%b want 1/0/1", xfers, m_axis_tvalid, fifo_empty);
        end
        checks++;
    endtask

    task automatic test_overflow();
        logic [DW-1:0] smp[10];
        int            k;
        foreach (smp[j]) smp[j] = DW'($urandom);
        do_reset();
        rate_div = 8'd255;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_data = smp[i];
            @(negedge clk);
            if (fifo_level !== LW'((i + 1 > 8) ? 8 : i + 1) || fifo_full !== (i >= 7) || overflow !== (i >= 8)) begin
                errors++;
                $display("FAIL overflow_fill write %0d: level=%0d full=%b ovf=%b want %0d/%b/%b",
                         i + 1, fifo_level, fifo_full, overflow, (i + 1 > 8) ? 8 : i + 1, i >= 7, i >= 8);
            end
            checks++;
        end
        wr_en = 1'b0;
        rate_div = 8'd0;
        m_axis_tready = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (k >= 8 || m_axis_tdata !== smp[k]) begin
                    errors++;
                    $display("FAIL overflow_drain #%0d: data %0d want %0d", k, m_axis_tdata, (k < 8) ? smp[k] : '0);
                end
                checks++;
                k++;
            end
            @(negedge clk);
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL overflow_model cyc %0d: got %h want %h", i, dut_obs(), model_obs());
            end
            checks++;
        end
        if (k != 8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: transfers=%0d ovf=%b want 8/1", k, overflow);
        end
        checks++;
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] exp_d[9];
        int            k;
        foreach (exp_d[j]) exp_d[j] = DW'($urandom);
        do_reset();
        rate_div = 8'd255;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = exp_d[i];
            @(negedge clk);
        end
        rate_div = 8'd0;
        wr_data  = exp_d[8];
        @(negedge clk);
        wr_en = 1'b0;
        if (fifo_level !== LW'(8) || fifo_full !== 1'b1 || overflow !== 1'b0 ||
            m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d[0]) begin
            errors++;
            $display("FAIL pushpop_full: level=%0d full=%b ovf=%b tvalid=%b tdata=%0d want 8/1/0/1/%0d",
                     fifo_level, fifo_full, overflow, m_axis_tvalid, m_axis_tdata, exp_d[0]);
        end
        checks++;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (k >= 9 || m_axis_tdata !== exp_d[k]) begin
                    errors++;
                    $display("FAIL pushpop_order #%0d: data %0d want %0d", k, m_axis_tdata, (k < 9) ? exp_d[k] : '0);
                end
                checks++;
                k++;
            end
            @(negedge clk);
        end
        if (k != 9) begin
            errors++;
            $display("FAIL pushpop_count: got %0d transfers want 9", k);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] smp[5];
        logic [DW-1:0] post[3];
        int            k;
        foreach (smp[j]) smp[j] = DW'($urandom);
        post = '{6'h11, 6'h22, 6'h33};
        do_reset();
        rate_div = 8'd0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = smp[i];
            @(negedge clk);
        end
        wr_en = 1'b0;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== smp[0] || fifo_level !== LW'(4)) begin
            errors++;
            $display("FAIL midreset_pre: tvalid=%b tdata=%0d level=%0d want 1/%0d/4",
                     m_axis_tvalid, m_axis_tdata, fifo_level, smp[0]);
        end
        checks++;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        if (dut_obs() !== RST_OBS) begin
            errors++;
            $display("FAIL midreset_async: got %h want %h", dut_obs(), RST_OBS);
        end
        checks++;
        @(negedge clk);
        reset = 1'b0;
        m_axis_tready = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (k >= 3 || m_axis_tdata !== post[k]) begin
                    errors++;
                    $display("FAIL midreset_order #%0d: data %0d want %0d", k, m_axis_tdata, (k < 3) ? post[k] : '0);
                end
                checks++;
                k++;
            end
            wr_en   = (i < 3);
            wr_data = (i < 3) ? post[i] : '0;
            @(negedge clk);
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL midreset_model cyc %0d: got %h want %h", i, dut_obs(), model_obs());
            end
            checks++;
        end
        if (k != 3) begin
            errors++;
            $display("FAIL midreset_count: got %0d transfers want 3", k);
        end
        checks++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i % 64 == 0) rate_div = 8'($urandom_range(0, 4));
            wr_en         = ($urandom_range(0, 2) != 0);
            wr_data       = DW'($urandom);
            m_axis_tready = ($urandom_range(0, 3) != 0);
`ifdef SAMPLE_SRC_TLAST_EN
            wr_last       = 1'($urandom);
`endif
            @(negedge clk);
            if (dut_obs() !== model_obs()) begin
                errors++;
                $display("FAIL random_model cyc %0d: got %h want %h", i, dut_obs(), model_obs());
            end
            checks++;
        end
        wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pacing();
        test_stall();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
